// File: rtl/enemy_grid_pkg.sv
// Shared definitions for the enemy formation sequencer: FSM encodings,
// sprite geometry and screen coordinate widths.
package enemy_grid_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SCAN   = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_SCAN   = ST_SCAN,
        S_ISSUE  = ST_ISSUE,
        S_WAIT   = ST_WAIT,
        S_FINISH = ST_FINISH
    } state_t;

    localparam int SPRITE_W      = 28;
    localparam int SPRITE_H      = 20;
    localparam int SPRITE_PIXELS = SPRITE_W * SPRITE_H;

    localparam int X_W = 9;
    localparam int Y_W = 8;

endpackage

// File: rtl/enemy_grid_addr.sv
// Combinational origin generator: row/col within the formation to screen
// X/Y. Sums are formed at 32 bits and wrap modulo the screen coordinate
// width; no clipping, the caller keeps the formation on screen.
module enemy_grid_addr
    import enemy_grid_pkg::*;
#(
    parameter int X_SPACING = 32,
    parameter int Y_SPACING = 24
) (
    input  logic [2:0]     row,
    input  logic [3:0]     col,
    input  logic [X_W-1:0] base_x,
    input  logic [Y_W-1:0] base_y,
    output logic [X_W-1:0] x_org,
    output logic [Y_W-1:0] y_org
);

    assign x_org = X_W'(32'(base_x) + 32'(col) * 32'(X_SPACING));
    assign y_org = Y_W'(32'(base_y) + 32'(row) * 32'(Y_SPACING));

endmodule

// File: rtl/enemy_grid_sequencer.sv
// Enemy formation sequencer: walks the ROWS x COLS grid row-major, skips
// dead enemies, hands each live sprite origin to the drawer with a one-cycle
// enable and waits for its done pulse. Pulses frame_done at pass end.
// Optional build macro ENEMY_GRID_TIMEOUT_EN adds a 12-bit drawer watchdog
// and the sticky timeout_err output.
module enemy_grid_sequencer
    import enemy_grid_pkg::*;
#(
    parameter int COLS      = 5,
    parameter int ROWS      = 3,
    parameter int X_SPACING = 32,
    parameter int Y_SPACING = 24
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [X_W-1:0]       base_x,
    input  logic [Y_W-1:0]       base_y,
    input  logic [ROWS*COLS-1:0] alive,
    input  logic                 draw_done,
`ifdef ENEMY_GRID_TIMEOUT_EN
    output logic                 timeout_err,
`endif
    output logic [X_W-1:0]       x_pos,
    output logic [Y_W-1:0]       y_pos,
    output logic                 draw_en,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [3:0]       col, col_nxt;
    logic [2:0]       row, row_nxt;
    logic [N-1:0]     alive_q;
    logic [X_W-1:0]   bx_q, ax;
    logic [Y_W-1:0]   by_q, ay;
    logic             last;
`ifdef ENEMY_GRID_TIMEOUT_EN
    logic [11:0]      wdog;
`endif

    assign last = (idx == IDX_W'(N - 1));

    // Next grid position: col wraps at the end of a row and bumps row.
    always_comb begin
        col_nxt = col + 4'd1;
        row_nxt = row;
        if (col == 4'(COLS - 1)) begin
            col_nxt = '0;
            row_nxt = row + 3'd1;
        end
    end

    enemy_grid_addr #(
        .X_SPACING (X_SPACING),
        .Y_SPACING (Y_SPACING)
    ) u_addr (
        .row    (row),
        .col    (col),
        .base_x (bx_q),
        .base_y (by_q),
        .x_org  (ax),
        .y_org  (ay)
    );

    // Sequencer FSM; draw_en/frame_done/busy are registered alongside the
    // state so each is a clean decode of the state being entered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            idx        <= '0;
            col        <= '0;
            row        <= '0;
            alive_q    <= '0;
            bx_q       <= '0;
            by_q       <= '0;
            x_pos      <= '0;
            y_pos      <= '0;
            draw_en    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef ENEMY_GRID_TIMEOUT_EN
            wdog        <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            draw_en    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        alive_q <= alive;
                        bx_q    <= base_x;
                        by_q    <= base_y;
                        idx     <= '0;
                        col     <= '0;
                        row     <= '0;
                        busy    <= 1'b1;
                        state   <= S_SCAN;
`ifdef ENEMY_GRID_TIMEOUT_EN
                        timeout_err <= 1'b0;
`endif
                    end
                end
                S_SCAN: begin
                    if (alive_q[idx]) begin
                        x_pos   <= ax;
                        y_pos   <= ay;
                        draw_en <= 1'b1;
                        state   <= S_ISSUE;
                    end else if (last) begin
                        frame_done <= 1'b1;
                        state      <= S_FINISH;
                    end else begin
                        idx <= idx + 1'b1;
                        col <= col_nxt;
                        row <= row_nxt;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
`ifdef ENEMY_GRID_TIMEOUT_EN
                    wdog  <= '0;
`endif
                end
                S_WAIT: begin
                    if (draw_done) begin
                        if (last) begin
                            frame_done <= 1'b1;
                            state      <= S_FINISH;
                        end else begin
                            idx   <= idx + 1'b1;
                            col   <= col_nxt;
                            row   <= row_nxt;
                            state <= S_SCAN;
                        end
                    end
`ifdef ENEMY_GRID_TIMEOUT_EN
                    // Counter reaches 4095 on this edge: give up on the drawer.
                    else if (wdog == 12'd4094) begin
                        wdog        <= wdog + 12'd1;
                        timeout_err <= 1'b1;
                        frame_done  <= 1'b1;
                        state       <= S_FINISH;
                    end else begin
                        wdog <= wdog + 12'd1;
                    end
`endif
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_grid_sequencer.sv
// Bench for enemy_grid_sequencer: mock drawer, a queue-based model of the
// draws a pass must produce, a per-cycle compare process, and directed
// tests with hand-computed origins and latencies.
module tb_enemy_grid_sequencer;

    localparam int COLS = 5;
    localparam int ROWS = 3;
    localparam int N    = ROWS * COLS;
    localparam int DLY  = 561;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic         draw_done = 1'b0;
    logic [8:0]   base_x = '0;
    logic [7:0]   base_y = '0;
    logic [N-1:0] alive = '0;
    logic [8:0]   x_pos;
    logic [7:0]   y_pos;
    logic         draw_en, busy, frame_done;
`ifdef ENEMY_GRID_TIMEOUT_EN
    logic         timeout_err;
`endif

    enemy_grid_sequencer #(
        .COLS (COLS), .ROWS (ROWS), .X_SPACING (32), .Y_SPACING (24)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .base_x     (base_x),
        .base_y     (base_y),
        .alive      (alive),
        .draw_done  (draw_done),
`ifdef ENEMY_GRID_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .draw_en    (draw_en),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit drv_on = 1'b1;

    // model and per-pass records
    int q_x[$];
    int q_y[$];
    bit busy_exp = 1'b0;
    bit prev_en  = 1'b0;
    int held_x = 0, held_y = 0;
    int st_cyc = 0, fd_cyc = 0, n_fd = 0, n_busy = 0, n_draw = 0;
    int en_cyc[$];
    int done_cyc[$];
    int dx[$];
    int dy[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    // Mock drawer: done pulse DLY cycles after each enable.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && drv_on && draw_en) begin
                repeat (DLY) @(posedge clk);
                #1 draw_done = 1'b1;
                @(posedge clk);
                #1 draw_done = 1'b0;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        bit nb;
        cyc++;
        if (!resetn) begin
            q_x.delete();
            q_y.delete();
            busy_exp = 1'b0;
            prev_en  = 1'b0;
            held_x   = 0;
            held_y   = 0;
        end else begin
            chk("busy", busy, busy_exp);
            if (busy) n_busy++;
            if (draw_en) begin
                n_draw++;
                en_cyc.push_back(cyc);
                dx.push_back(int'(x_pos));
                dy.push_back(int'(y_pos));
                chk("en_width", prev_en, 0);
                chk("draw_pending", q_x.size() > 0, 1);
                if (q_x.size() > 0) begin
                    held_x = q_x.pop_front();
                    held_y = q_y.pop_front();
                    chk("draw_x", x_pos, held_x);
                    chk("draw_y", y_pos, held_y);
                end
            end else begin
                chk("hold_x", x_pos, held_x);
                chk("hold_y", y_pos, held_y);
            end
            if (draw_done && busy_exp) done_cyc.push_back(cyc);
            nb = busy_exp;
            if (start && !busy_exp) begin
                for (int i = 0; i < N; i++) begin
                    if (alive[i]) begin
                        q_x.push_back((int'(base_x) + (i % COLS) * 32) % 512);
                        q_y.push_back((int'(base_y) + (i / COLS) * 24) % 256);
                    end
                end
                st_cyc = cyc;
                nb = 1'b1;
            end
            if (frame_done) begin
                n_fd++;
                fd_cyc = cyc;
                chk("fd_in_pass", busy_exp, 1);
`ifdef ENEMY_GRID_TIMEOUT_EN
                if (timeout_err) begin
                    q_x.delete();
                    q_y.delete();
                end
`endif
                chk("fd_left", q_x.size(), 0);
                nb = 1'b0;
            end
            busy_exp = nb;
            prev_en  = draw_en;
        end
    end

    task automatic clear_rec();
        n_fd = 0; n_draw = 0; n_busy = 0;
        en_cyc.delete(); done_cyc.delete(); dx.delete(); dy.delete();
    endtask

    task automatic start_pass(input logic [N-1:0] m, input int bx, input int by);
        clear_rec();
        alive  = m;
        base_x = 9'(bx);
        base_y = 8'(by);
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_frame(input int lim);
        int k = 0;
        while (n_fd == 0 && k < lim) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("frame_seen", n_fd, 1);
    endtask

    initial begin
        int k;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_en", draw_en, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_x", x_pos, 0);
        chk("rst_y", y_pos, 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // all alive, base (20,10)
        start_pass('1, 20, 10);
        wait_frame(12000);
        chk("t1_draws", n_draw, 15);
        chk("t1_x0", qat(dx, 0), 20);
        chk("t1_y0", qat(dy, 0), 10);
        chk("t1_x6", qat(dx, 6), 52);
        chk("t1_y6", qat(dy, 6), 34);
        chk("t1_x14", qat(dx, 14), 148);
        chk("t1_y14", qat(dy, 14), 58);
        chk("t1_first_lat", qat(en_cyc, 0) - st_cyc, 2);
        chk("t1_fd_lat", fd_cyc - qat(done_cyc, done_cyc.size() - 1), 1);
        repeat (3) @(posedge clk); #1;

        // all dead
        start_pass('0, 7, 7);
        wait_frame(100);
        chk("t2_draws", n_draw, 0);
        chk("t2_fd_lat", fd_cyc - st_cyc, 16);
        chk("t2_busy_cyc", n_busy, 16);
        repeat (3) @(posedge clk); #1;

        // only enemies 0 and 14
        start_pass(15'h4001, 100, 50);
        wait_frame(3000);
        chk("t3_draws", n_draw, 2);
        chk("t3_x0", qat(dx, 0), 100);
        chk("t3_y0", qat(dy, 0), 50);
        chk("t3_x1", qat(dx, 1), 228);
        chk("t3_y1", qat(dy, 1), 98);
        chk("t3_gap", qat(en_cyc, 1) - qat(done_cyc, 0) - 1, 14);
        repeat (3) @(posedge clk); #1;

        // start and mask changes mid-pass are ignored
        start_pass(15'h0025, 40, 30);
        k = 0;
        while (n_draw == 0 && k < 50) begin @(posedge clk); k++; end
        #1;
        alive  = '1;
        base_x = 9'd300;
        base_y = 8'd200;
        start  = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        wait_frame(3000);
        chk("t4_draws", n_draw, 3);
        chk("t4_x2", qat(dx, 2), 40);
        chk("t4_y2", qat(dy, 2), 54);
        repeat (3) @(posedge clk); #1;

        // asynchronous reset during WAIT
        drv_on = 1'b0;
        start_pass('1, 20, 10);
        k = 0;
        while (n_draw == 0 && k < 50) begin @(posedge clk); k++; end
        repeat (5) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_en", draw_en, 0);
        chk("t5_x", x_pos, 0);
        chk("t5_y", y_pos, 0);
        chk("t5_fd", frame_done, 0);
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t5_no_fd", n_fd, 0);
        drv_on = 1'b1;
        // fresh pass with coordinate wrap: (500+128)%512, (250+48)%256
        start_pass(15'h4000, 500, 250);
        wait_frame(3000);
        chk("t5_draws", n_draw, 1);
        chk("t5_wrap_x", qat(dx, 0), 116);
        chk("t5_wrap_y", qat(dy, 0), 42);
        repeat (3) @(posedge clk); #1;

`ifdef ENEMY_GRID_TIMEOUT_EN
        // silent drawer: watchdog abandons the pass
        drv_on = 1'b0;
        start_pass(15'h0001, 0, 0);
        wait_frame(5000);
        chk("to_lat", fd_cyc - qat(en_cyc, 0), 4096);
        chk("to_err", timeout_err, 1);
        repeat (3) @(posedge clk); #1;
        drv_on = 1'b1;
        start_pass(15'h0001, 0, 0);
        chk("to_clear", timeout_err, 0);
        wait_frame(3000);
        repeat (3) @(posedge clk); #1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
